display_scan_ctrl: RTL and testbench
====================================

Name: display_scan_ctrl

Overview:
- Time-multiplexes NUM_DIGITS common-anode 7-segment digits over one shared segment bus and one shared hex-to-segment decoder.
- Sequences digit select, inserts an all-off blanking gap before each digit switch to prevent ghosting, and double-buffers the displayed value so updates apply only at frame boundaries (no tearing).
- Sits between the numeric datapath (counters, ALU results) and the board pins.

Parameters:
- NUM_DIGITS, 4, number of multiplexed digits (2..8).
- SCAN_DIV, 50000, clk cycles per digit slot (blank + show); must be > BLANK_CYC+1.
- BLANK_CYC, 16, cycles of all-off at the start of each slot; must be >= 1.

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  asynchronous active-low reset.
- habilita_i  in  1  scan enable; low forces display dark.
- valor_i  in  4*NUM_DIGITS  hex nibbles; nibble k drives digit k, digit 0 = rightmost.
- punto_i  in  NUM_DIGITS  decimal-point request per digit, active-high.
- carga_i  in  1  one-cycle load strobe; samples valor_i and punto_i.
- segmentos_o  out  7  segments {g,f,e,d,c,b,a}, active-low, registered.
- punto_o  out  1  decimal point, active-low, registered.
- anodos_o  out  NUM_DIGITS  digit select, active-low one-cold, registered.
- fin_trama_o  out  1  one-cycle pulse when the last digit's slot ends (frame wrap).

Behaviour:
- Single clock clk_i; reset rst_ni is asynchronous and active-low.
- Reset values:
  - segmentos_o = 7'b1111111, punto_o = 1, anodos_o = all 1s, fin_trama_o = 0.
  - State IDLE, digit index idx = 0, slot counter = 0.
  - Shadow register and display register = 0; pendiente = 0.
- Slot counter width is $clog2(SCAN_DIV); it counts 0..SCAN_DIV-1 within each slot.
- State machine:
  - IDLE: anodes all 1, segments all 1. If habilita_i = 1, go to BLANK with idx = 0 and counter = 0.
  - BLANK: anodes all 1, segments all 1. When counter == BLANK_CYC-1, go to SHOW.
  - SHOW: anodos_o[idx] = 0, all other anodes 1. segmentos_o = decode(display nibble idx); punto_o = ~display point idx. When counter == SCAN_DIV-1:
    - Return to BLANK with idx = idx+1.
    - If idx == NUM_DIGITS-1: idx wraps to 0 and fin_trama_o pulses for exactly one cycle.
  - Any state: habilita_i = 0 goes to IDLE on the next edge. Outputs go dark that cycle; idx and counter clear.
- Outputs are registered: anodes and segments change on the same edge as the state transition (no extra latency between them).
- Decode is hex 0-F, active-low:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000
  - 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011
  - C = 1000110, d = 0100001, E = 0000110, F = 0001110
- Double buffer:
  - carga_i = 1: shadow <= {valor_i, punto_i}; pendiente <= 1.
  - At frame wrap with pendiente = 1: display <= shadow; pendiente <= 0.
  - carga_i on the wrap cycle itself: display takes the incoming valor_i/punto_i directly; pendiente stays 0.
  - While in IDLE, carga_i updates display immediately, so the first frame after enable shows the latest value.
- Back-to-back carga_i: the last one before the wrap wins.
- Reset asserted mid-slot: all outputs go dark immediately (asynchronous); the loaded value is lost.

Optional Feature:
- Macro: DISPLAY_SCAN_LZB_EN.
- Defined: leading-zero blanking. At frame wrap, compute a blank mask from display: digit k is blanked if its nibble and all higher nibbles are 0 and k != 0.
  - A blanked digit's slot keeps its anode high and its segments all 1.
  - Timing is unchanged: the slot is still consumed.
- Undefined: every digit is always shown; no mask logic is synthesised.

Decomposition:
- Package display_pkg:
  - 7-bit segment constants SEG_OFF = 7'h7F and hex-digit patterns.
  - State enum type scan_state_t {IDLE, BLANK, SHOW}.
- Sub-module hex7seg_dec: combinational 4-bit to 7-bit active-low decoder, instantiated once and fed by the mux of the display nibble at idx.

Test Plan (NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2):
- Reset release, habilita_i = 1, display 16'h1234 via carga_i while IDLE:
  - anodos_o sequence 1110 (4), 1101 (3), 1011 (2), 0111 (1), each low for 6 cycles after 2 dark cycles.
  - segmentos_o for digit 0 = 0011001.
  - fin_trama_o pulses every 32 cycles.
- carga_i 16'hABCD mid-frame: the current frame still shows 1234; the next frame shows D, C, B, A.
- carga_i coincident with the fin_trama_o cycle: the new value appears in the very next SHOW slot.
- habilita_i low during SHOW of digit 2:
  - Next cycle anodes = 1111 and segments = 7F.
  - Re-enable: 2 blank cycles, then digit 0.
- Asynchronous rst_ni pulse between clock edges mid-SHOW: outputs go dark without waiting for a clock edge; after release, the display value is 0.
- DISPLAY_SCAN_LZB_EN defined, value 16'h0050: digits 3 and 2 never assert their anode; digit 1 shows 5 and digit 0 shows 0. Value 0: only digit 0 lights.

Source files
------------

// File: rtl/display_pkg.sv
// Shared constants and types for the multiplexed 7-segment scan controller.
package display_pkg;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns indexed by hex value
  localparam logic [6:0] SEG_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic [1:0] {IDLE, BLANK, SHOW} scan_state_t;

endpackage

// File: rtl/hex7seg_dec.sv
// Combinational hex nibble to active-low 7-segment pattern decoder.
module hex7seg_dec
  import display_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_HEX[hex_i];

endmodule

// File: rtl/display_scan_ctrl.sv
// Multiplexed common-anode 7-segment scan controller with blanking gaps and a frame-synchronous
// double buffer. Define DISPLAY_SCAN_LZB_EN to enable leading-zero blanking.
module display_scan_ctrl
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned BLANK_CYC  = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    habilita_i,
  input  logic [4*NUM_DIGITS-1:0] valor_i,
  input  logic [NUM_DIGITS-1:0]   punto_i,
  input  logic                    carga_i,
  output logic [6:0]              segmentos_o,
  output logic                    punto_o,
  output logic [NUM_DIGITS-1:0]   anodos_o,
  output logic                    fin_trama_o
);

  localparam int unsigned CntW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CntW-1:0] CntBlankEnd = CntW'(BLANK_CYC - 1);
  localparam logic [CntW-1:0] CntSlotEnd  = CntW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast     = IdxW'(NUM_DIGITS - 1);

  scan_state_t             state_q, state_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
  logic                    wrap;
  logic [4*NUM_DIGITS-1:0] disp_val_q, shad_val_q;
  logic [NUM_DIGITS-1:0]   disp_pt_q, shad_pt_q;
  logic                    pend_q;
  logic [6:0]              seg_q, seg_d, dec_seg;
  logic                    pt_q, pt_d, fin_q, fin_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d, blank_mask;
  logic [3:0]              nib;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q + 1'b1;
    wrap    = 1'b0;
    if (!habilita_i) begin
      state_d = IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          state_d = BLANK;
          idx_d   = '0;
          cnt_d   = '0;
        end
        BLANK: if (cnt_q == CntBlankEnd) state_d = SHOW;
        SHOW: begin
          if (cnt_q == CntSlotEnd) begin
            state_d = BLANK;
            cnt_d   = '0;
            if (idx_q == IdxLast) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        default: begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

`ifdef DISPLAY_SCAN_LZB_EN
  // A digit is dark when it and every higher nibble are zero; digit 0 always shows.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    blank_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      zero_above    = zero_above & (disp_val_q[4*k +: 4] == 4'h0);
      blank_mask[k] = zero_above;
    end
  end
`else
  assign blank_mask = '0;
`endif

  // Outputs are built from the next state so anodes and segments move with the transition.
  assign nib = disp_val_q[{idx_d, 2'b00} +: 4];

  hex7seg_dec u_dec (
    .hex_i (nib),
    .seg_o (dec_seg)
  );

  always_comb begin
    an_d  = '1;
    seg_d = SEG_OFF;
    pt_d  = 1'b1;
    if (state_d == SHOW && !blank_mask[idx_d]) begin
      an_d[idx_d] = 1'b0;
      seg_d       = dec_seg;
      pt_d        = ~disp_pt_q[idx_d];
    end
    // High during the final cycle of the last digit's slot, i.e. the wrap cycle
    fin_d = (state_d == SHOW) && (idx_d == IdxLast) && (cnt_d == CntSlotEnd);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      disp_val_q <= '0;
      disp_pt_q  <= '0;
      shad_val_q <= '0;
      shad_pt_q  <= '0;
      pend_q     <= 1'b0;
      seg_q      <= SEG_OFF;
      pt_q       <= 1'b1;
      an_q       <= '1;
      fin_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
      pt_q    <= pt_d;
      an_q    <= an_d;
      fin_q   <= fin_d;
      if (state_q == IDLE || wrap) begin
        if (carga_i) begin
          disp_val_q <= valor_i;
          disp_pt_q  <= punto_i;
          shad_val_q <= valor_i;
          shad_pt_q  <= punto_i;
          pend_q     <= 1'b0;
        end else if (pend_q) begin
          disp_val_q <= shad_val_q;
          disp_pt_q  <= shad_pt_q;
          pend_q     <= 1'b0;
        end
      end else if (carga_i) begin
        shad_val_q <= valor_i;
        shad_pt_q  <= punto_i;
        pend_q     <= 1'b1;
      end
    end
  end

  assign segmentos_o = seg_q;
  assign punto_o     = pt_q;
  assign anodos_o    = an_q;
  assign fin_trama_o = fin_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl: directed vector tables plus randomized traffic
// checked against a slot-arithmetic reference model.
module tb_display_scan_ctrl;

  localparam int N = 4;
  localparam int D = 8;
  localparam int B = 2;
  localparam logic [12:0] DARK = {7'h7F, 1'b1, 4'hF, 1'b0};

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b1;
  logic        habilita_i = 1'b0;
  logic        carga_i = 1'b0;
  logic [15:0] valor_i = '0;
  logic [3:0]  punto_i = '0;
  logic [6:0]  segmentos_o;
  logic        punto_o;
  logic [3:0]  anodos_o;
  logic        fin_trama_o;

  display_scan_ctrl #(
    .NUM_DIGITS (N),
    .SCAN_DIV   (D),
    .BLANK_CYC  (B)
  ) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .habilita_i  (habilita_i),
    .valor_i     (valor_i),
    .punto_i     (punto_i),
    .carga_i     (carga_i),
    .segmentos_o (segmentos_o),
    .punto_o     (punto_o),
    .anodos_o    (anodos_o),
    .fin_trama_o (fin_trama_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: time since enable, shown value, pending value
  bit          m_run;
  int          m_t;
  logic [15:0] m_val, m_sh_val;
  logic [3:0]  m_pt, m_sh_pt;
  bit          m_pend;

  typedef struct {
    int         t;
    logic [3:0] an;
    logic [6:0] seg;
    logic       fin;
  } vec_t;

  function automatic logic [6:0] seg_of(input logic [3:0] h);
    case (h)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic bit blanked(input int k);
`ifdef DISPLAY_SCAN_LZB_EN
    return (k != 0) && ((m_val >> (4 * k)) == 16'h0);
`else
    return (k < 0);
`endif
  endfunction

  function automatic logic [12:0] model_out();
    logic [12:0] o;
    int ph, dig;
    o = DARK;
    if (m_run) begin
      ph   = m_t % D;
      dig  = (m_t / D) % N;
      o[0] = (ph == D - 1) && (dig == N - 1);
      if (ph >= B && !blanked(dig)) begin
        o[12:6] = seg_of(m_val[4*dig +: 4]);
        o[5]    = ~m_pt[dig];
        o[4:1]  = ~(4'b0001 << dig);
      end
    end
    return o;
  endfunction

  task automatic model_reset();
    m_run = 0; m_t = 0; m_pend = 0;
    m_val = '0; m_pt = '0; m_sh_val = '0; m_sh_pt = '0;
  endtask

  task automatic model_edge();
    bit wrap;
    wrap = m_run && habilita_i && (m_t % D == D - 1) && ((m_t / D) % N == N - 1);
    if (!m_run || wrap) begin
      if (carga_i) begin
        m_val = valor_i; m_pt = punto_i; m_sh_val = valor_i; m_sh_pt = punto_i; m_pend = 0;
      end else if (m_pend) begin
        m_val = m_sh_val; m_pt = m_sh_pt; m_pend = 0;
      end
    end else if (carga_i) begin
      m_sh_val = valor_i; m_sh_pt = punto_i; m_pend = 1;
    end
    if (!habilita_i) m_run = 0;
    else if (!m_run) begin m_run = 1; m_t = 0; end
    else m_t++;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (model t=%0d)", name, got, exp, m_t);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    chk("scan", {19'd0, segmentos_o, punto_o, anodos_o, fin_trama_o}, {19'd0, model_out()});
  endtask

  task automatic run_to(input int t);
    for (int i = 0; i < 2000 && !(m_run && m_t == t); i++) step();
    if (!(m_run && m_t == t)) begin
      n_vec++;
      n_bad++;
      $display("FAIL run_to: reached t=%0d, expected t=%0d", m_t, t);
    end
  endtask

  task automatic dchk(input string name, input vec_t v);
    chk(name, {20'd0, anodos_o, segmentos_o, fin_trama_o}, {20'd0, v.an, v.seg, v.fin});
  endtask

  vec_t frame1 [10];

  initial begin
    frame1[0] = '{0,  4'hF, 7'h7F,       1'b0};
    frame1[1] = '{2,  4'hE, 7'b0011001,  1'b0};
    frame1[2] = '{7,  4'hE, 7'b0011001,  1'b0};
    frame1[3] = '{8,  4'hF, 7'h7F,       1'b0};
    frame1[4] = '{10, 4'hD, 7'b0110000,  1'b0};
    frame1[5] = '{18, 4'hB, 7'b0100100,  1'b0};
    frame1[6] = '{26, 4'h7, 7'b1111001,  1'b0};
    frame1[7] = '{30, 4'h7, 7'b1111001,  1'b0};
    frame1[8] = '{31, 4'h7, 7'b1111001,  1'b1};
    frame1[9] = '{32, 4'hF, 7'h7F,       1'b0};

    model_reset();
    #2 rst_ni = 1'b0;
    #2 chk("reset", {19'd0, segmentos_o, punto_o, anodos_o, fin_trama_o}, {19'd0, DARK});
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Load 1234 while idle, then enable
    carga_i = 1'b1; valor_i = 16'h1234; punto_i = 4'b0000;
    step();
    carga_i = 1'b0; habilita_i = 1'b1;
    step();
    for (int i = 0; i < 10; i++) begin
      run_to(frame1[i].t);
      dchk($sformatf("frame1[%0d]", i), frame1[i]);
    end

    // Mid-frame load: current frame keeps 1234, next frame shows ABCD
    run_to(40);
    carga_i = 1'b1; valor_i = 16'hABCD;
    step();
    carga_i = 1'b0;
    run_to(42); dchk("old_frame_d1", '{42, 4'hD, 7'b0110000, 1'b0});
    run_to(66); dchk("new_frame_d0", '{66, 4'hE, 7'b0100001, 1'b0});
    run_to(90); dchk("new_frame_d3", '{90, 4'h7, 7'b0001000, 1'b0});

    // Load on the wrap cycle lands in the very next slot
    run_to(95); dchk("wrap_cycle", '{95, 4'h7, 7'b0001000, 1'b1});
    carga_i = 1'b1; valor_i = 16'h5A6F; punto_i = 4'b0001;
    step();
    carga_i = 1'b0;
    run_to(98); dchk("wrap_load_d0", '{98, 4'hE, 7'b0001110, 1'b0});
    chk("wrap_load_dp", {31'd0, punto_o}, 32'd0);

    // Disable during digit 2 show, then re-enable
    run_to(115); dchk("show_d2", '{115, 4'hB, 7'b0001000, 1'b0});
    habilita_i = 1'b0;
    step(); dchk("disable_dark", '{0, 4'hF, 7'h7F, 1'b0});
    step(); step();
    habilita_i = 1'b1;
    step(); dchk("reen_t0", '{0, 4'hF, 7'h7F, 1'b0});
    step(); dchk("reen_t1", '{1, 4'hF, 7'h7F, 1'b0});
    step(); dchk("reen_t2", '{2, 4'hE, 7'b0001110, 1'b0});

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      habilita_i = ($urandom_range(0, 59) != 0);
      carga_i    = ($urandom_range(0, 11) == 0);
      valor_i    = 16'($urandom);
      punto_i    = 4'($urandom);
      step();
    end
    habilita_i = 1'b1; carga_i = 1'b0;

    // Asynchronous reset pulse between edges during a show phase
    for (int i = 0; i < 40 && !(m_run && m_t % D == 4); i++) step();
    chk("pre_reset_lit", {28'd0, anodos_o}, {28'd0, model_out()[4:1]});
    @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1 chk("async_reset", {19'd0, segmentos_o, punto_o, anodos_o, fin_trama_o}, {19'd0, DARK});
    #1 rst_ni = 1'b1;
    model_reset();
    step();
    run_to(2); dchk("post_reset_zero", '{2, 4'hE, 7'b1000000, 1'b0});

    // Leading-zero cases
    habilita_i = 1'b0;
    step();
    carga_i = 1'b1; valor_i = 16'h0050; punto_i = 4'b0000;
    step();
    carga_i = 1'b0; habilita_i = 1'b1;
    step();
    run_to(2);  dchk("lz50_d0", '{2, 4'hE, 7'b1000000, 1'b0});
    run_to(10); dchk("lz50_d1", '{10, 4'hD, 7'b0010010, 1'b0});
`ifdef DISPLAY_SCAN_LZB_EN
    run_to(18); dchk("lz50_d2", '{18, 4'hF, 7'h7F, 1'b0});
    run_to(26); dchk("lz50_d3", '{26, 4'hF, 7'h7F, 1'b0});
`else
    run_to(18); dchk("lz50_d2", '{18, 4'hB, 7'b1000000, 1'b0});
    run_to(26); dchk("lz50_d3", '{26, 4'h7, 7'b1000000, 1'b0});
`endif
    habilita_i = 1'b0;
    step();
    carga_i = 1'b1; valor_i = 16'h0000;
    step();
    carga_i = 1'b0; habilita_i = 1'b1;
    step();
    run_to(2); dchk("lz0_d0", '{2, 4'hE, 7'b1000000, 1'b0});
`ifdef DISPLAY_SCAN_LZB_EN
    run_to(10); dchk("lz0_d1", '{10, 4'hF, 7'h7F, 1'b0});
`else
    run_to(10); dchk("lz0_d1", '{10, 4'hD, 7'b1000000, 1'b0});
`endif
    run_to(31);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
